// File: rtl/l2_ocapi_responder_pkg.sv
// l2_ocapi_responder_pkg: widths shared by l2_stream_ptr and the OpenCAPI responder.
// Holds the default L2 line count, the response tag width and the latency counter width.
package l2_ocapi_responder_pkg;

    localparam int L2_NCL_DEF = 256;
    localparam int TAG_W      = 8;
    localparam int LAT_W      = 8;

endpackage

// File: rtl/l2_ocapi_rsp_fifo.sv
// l2_ocapi_rsp_fifo: circular store of {addr, tag} for outstanding OpenCAPI requests.
// Ports: push/pop/flush controls, write data, head data, wrapping pointers, occupancy.
module l2_ocapi_rsp_fifo
    import l2_ocapi_responder_pkg::*;
#(
    parameter int aw    = 8,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [aw-1:0]              wr_addr,
    input  logic [TAG_W-1:0]           wr_tag,
    output logic [aw-1:0]              rd_addr,
    output logic [TAG_W-1:0]           rd_tag,
    output logic [$clog2(depth)-1:0]   wr_ptr,
    output logic [$clog2(depth)-1:0]   rd_ptr,
    output logic [$clog2(depth+1)-1:0] cnt,
    output logic                       empty
);

    logic [aw-1:0]    addr_q [depth];
    logic [TAG_W-1:0] tag_q  [depth];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < depth; i++) begin
                addr_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr] <= wr_addr;
                tag_q[wr_ptr]  <= wr_tag;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_addr = addr_q[rd_ptr];
    assign rd_tag  = tag_q[rd_ptr];
    assign empty   = (cnt == '0);

endmodule

// File: rtl/l2_ocapi_responder.sv
// l2_ocapi_responder: delays each accepted request by a fixed latency and returns it in order.
// Ports: req v/r/addr in, rsp v/r/addr/tag out, flush, outstanding count.
module l2_ocapi_responder
    import l2_ocapi_responder_pkg::*;
#(
    parameter int l2_ncl  = L2_NCL_DEF,
    parameter int depth   = 8,
    parameter int latency = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_req_v,
    output logic                       i_req_r,
    input  logic [$clog2(l2_ncl)-1:0]  i_req_addr,
    output logic                       o_rsp_v,
    input  logic                       o_rsp_r,
    output logic [$clog2(l2_ncl)-1:0]  o_rsp_addr,
    output logic [TAG_W-1:0]           o_rsp_tag,
    input  logic                       i_flush_v,
    output logic [$clog2(depth+1)-1:0] o_cnt
);

    localparam int l2_ncl_width = $clog2(l2_ncl);
    localparam int pw           = $clog2(depth);
    localparam int cw           = $clog2(depth+1);

    logic                    rdy_q;
    logic [TAG_W-1:0]        tag_q;
    logic [LAT_W-1:0]        rem_q [depth];
    logic                    push;
    logic                    pop;
    logic                    empty;
    logic [pw-1:0]           wr_ptr;
    logic [pw-1:0]           rd_ptr;
    logic [l2_ncl_width-1:0] head_addr;
    logic [TAG_W-1:0]        head_tag;

    // Ready looks only at registered occupancy, so a same-cycle pop
    // never frees a slot for a push.
    assign i_req_r = rdy_q & (o_cnt != cw'(depth)) & !i_flush_v;
    assign o_rsp_v = !empty & (rem_q[rd_ptr] == '0) & !i_flush_v;

    assign o_rsp_addr = o_rsp_v ? head_addr : '0;
    assign o_rsp_tag  = o_rsp_v ? head_tag : '0;

    assign push = i_req_v & i_req_r;
    assign pop  = o_rsp_v & o_rsp_r;

    l2_ocapi_rsp_fifo #(
        .aw    (l2_ncl_width),
        .depth (depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (i_flush_v),
        .wr_addr (i_req_addr),
        .wr_tag  (tag_q),
        .rd_addr (head_addr),
        .rd_tag  (head_tag),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .cnt     (o_cnt),
        .empty   (empty)
    );

    // Per-slot countdown: loaded on push, then runs down to zero.
    // Free slots always hold zero, so counting every slot is harmless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q <= 1'b0;
            tag_q <= '0;
            for (int i = 0; i < depth; i++) begin
                rem_q[i] <= '0;
            end
        end else begin
            rdy_q <= 1'b1;
            if (i_flush_v) begin
                tag_q <= '0;
                for (int i = 0; i < depth; i++) begin
                    rem_q[i] <= '0;
                end
            end else begin
                if (push) begin
                    tag_q <= tag_q + 1'b1;
                end
                for (int i = 0; i < depth; i++) begin
                    if (push && wr_ptr == pw'(i)) begin
                        rem_q[i] <= LAT_W'(latency);
                    end else if (rem_q[i] != '0) begin
                        rem_q[i] <= rem_q[i] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_ocapi_responder.sv
// tb_l2_ocapi_responder: directed stimulus with a response scoreboard.
// A negedge monitor pops expected {addr, tag, accept cycle} on each response handshake.
module tb_l2_ocapi_responder;

    localparam int LAT   = 16;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_req_v = 1'b0;
    logic       i_req_r;
    logic [7:0] i_req_addr = 8'hAA;
    logic       o_rsp_v;
    logic       o_rsp_r = 1'b0;
    logic [7:0] o_rsp_addr;
    logic [7:0] o_rsp_tag;
    logic       i_flush_v = 1'b0;
    logic [3:0] o_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pops = 0;
    int pops0;
    logic [7:0] exp_tag = 8'd0;
    logic [7:0] head_tag;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] tag;
        int         acc;
        bit         exact;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    l2_ocapi_responder #(
        .l2_ncl  (256),
        .depth   (DEPTH),
        .latency (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req_v    (i_req_v),
        .i_req_r    (i_req_r),
        .i_req_addr (i_req_addr),
        .o_rsp_v    (o_rsp_v),
        .o_rsp_r    (o_rsp_r),
        .o_rsp_addr (o_rsp_addr),
        .o_rsp_tag  (o_rsp_tag),
        .i_flush_v  (i_flush_v),
        .o_cnt      (o_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_rsp_v && o_rsp_r) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_rsp actual=tag %0h required=none",
                         o_rsp_tag);
            end else begin
                mon_e = sb.pop_front();
                pops++;
                chk("rsp_addr", o_rsp_addr, mon_e.addr);
                chk("rsp_tag", o_rsp_tag, mon_e.tag);
                if (mon_e.exact)
                    chk("rsp_lat_exact", cyc, mon_e.acc + LAT);
                else
                    chk("rsp_lat_min", 32'(cyc >= mon_e.acc + LAT), 1);
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input bit exact);
        bit done = 0;
        i_req_v = 1'b1;
        i_req_addr = a;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (i_req_r) begin
                sb.push_back('{a, exp_tag, cyc + 1, exact});
                exp_tag++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        i_req_v = 1'b0;
        i_req_addr = 8'hAA;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic drain(input string name);
        bit ok = 0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0) ok = 1;
        end
        chk({name, "_drain"}, 32'(ok), 1);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (o_rsp_v) ok = 1;
        end
        chk({name, "_valid_seen"}, 32'(ok), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        o_rsp_r = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_r", i_req_r, 0);
        chk("rst_rsp_v", o_rsp_v, 0);
        chk("rst_cnt", o_cnt, 0);
        chk("rst_addr", o_rsp_addr, 0);
        chk("rst_tag", o_rsp_tag, 0);
        align();
        reset = 1'b1;
        @(negedge clk);
        chk("rel_req_r_before_edge", i_req_r, 0);
        @(negedge clk);
        chk("rel_req_r_after_edge", i_req_r, 1);
        align();

        // single request, exact latency
        send(8'h05, 1);
        @(negedge clk);
        chk("t1_cnt1", o_cnt, 1);
        drain("t1");
        chk("t1_cnt0", o_cnt, 0);
        align();

        // fill under back-pressure, stalled ninth request
        o_rsp_r = 1'b0;
        head_tag = exp_tag;
        for (int i = 0; i < DEPTH; i++) send(8'h10 + 8'(i), 0);
        @(negedge clk);
        chk("t2_cnt_full", o_cnt, 8);
        chk("t2_req_r_full", i_req_r, 0);
        i_req_v = 1'b1;
        i_req_addr = 8'h99;
        wait_valid("t2");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_hold_v", o_rsp_v, 1);
            chk("t2_hold_addr", o_rsp_addr, 8'h10);
            chk("t2_hold_tag", o_rsp_tag, head_tag);
            chk("t2_stall_req_r", i_req_r, 0);
            chk("t2_stall_cnt", o_cnt, 8);
        end
        align();
        o_rsp_r = 1'b1;
        send(8'h99, 0);
        drain("t2");
        chk("t2_cnt0", o_cnt, 0);
        align();

        // flush with four outstanding
        o_rsp_r = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 0);
        @(negedge clk);
        chk("t3_cnt4", o_cnt, 4);
        wait_valid("t3");
        align();
        i_flush_v = 1'b1;
        @(negedge clk);
        chk("t3_flush_rsp_v", o_rsp_v, 0);
        chk("t3_flush_req_r", i_req_r, 0);
        sb.delete();
        exp_tag = 8'd0;
        align();
        i_flush_v = 1'b0;
        @(negedge clk);
        chk("t3_post_cnt", o_cnt, 0);
        chk("t3_post_rsp_v", o_rsp_v, 0);
        align();
        o_rsp_r = 1'b1;
        send(8'h42, 1);
        drain("t3");
        chk("t3_cnt0", o_cnt, 0);
        align();

        // 300 requests, tag wrap
        pops0 = pops;
        for (int i = 0; i < 300; i++) send(8'(i) ^ 8'h5A, 0);
        drain("t4");
        chk("t4_pop_count", pops - pops0, 300);
        chk("t4_cnt0", o_cnt, 0);
        align();

        // reset with three outstanding
        o_rsp_r = 1'b0;
        for (int i = 0; i < 3; i++) send(8'h30 + 8'(i), 0);
        @(negedge clk);
        chk("t5_cnt3", o_cnt, 3);
        wait_valid("t5");
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_req_r", i_req_r, 0);
        chk("t5_rst_rsp_v", o_rsp_v, 0);
        chk("t5_rst_addr", o_rsp_addr, 0);
        chk("t5_rst_tag", o_rsp_tag, 0);
        chk("t5_rst_cnt", o_cnt, 0);
        sb.delete();
        exp_tag = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        o_rsp_r = 1'b1;
        repeat (40) @(negedge clk);
        chk("t5_no_stale_v", o_rsp_v, 0);
        chk("t5_no_stale_cnt", o_cnt, 0);
        align();
        send(8'h77, 1);
        drain("t5");
        chk("t5_cnt0", o_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
